// File: rtl/cache_axi_pkg.sv
// Shared constants and FSM state types for the cache/AXI line arbiter.
package cache_axi_pkg;

  localparam int unsigned LINE_BEATS = 4;
  localparam logic [3:0]  ID_ICACHE  = 4'd0;
  localparam logic [3:0]  ID_DCACHE  = 4'd1;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'd2;
  localparam logic [7:0]  AXI_LEN_LINE   = 8'(LINE_BEATS - 1);
  localparam logic [1:0]  LAST_BEAT      = 2'(LINE_BEATS - 1);
  localparam logic [31:0] LINE_MASK      = 32'hffff_fff0;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wr_state_t;

  // Operands are line numbers (address bits [31:4]).
  function automatic logic same_line(input logic [27:0] a, input logic [27:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; req[0] = icache, req[1] = dcache.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_d;  // 1 when dcache held the most recent grant

  always_comb begin
    grant = '0;
    if (en) begin
      if (req[0] && req[1]) grant = last_d ? 2'b01 : 2'b10;
      else                  grant = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       last_d <= 1'b0;
    else if (|grant) last_d <= grant[1];
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master between icache line reads and dcache line reads/write-backs.
module cache_axi_arbiter
  import cache_axi_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_rd_req,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  input  logic         d_rd_req,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic [127:0] ret_data,
  input  logic         d_wr_req,
  input  logic [31:0]  d_wr_addr,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic         arvalid,
  input  logic         arready,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic         awvalid,
  input  logic         awready,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_t      r_state;
  wr_state_t      w_state;
  logic [1:0]     rbeat, wbeat;
  logic           r_owner_d;
  logic [127:0]   wr_line;
  logic           rd_en, rd_hazard;
  logic [1:0]     rd_req, rd_grant;

  // A dcache read of the line being written back (or accepted for write-back
  // this very cycle) is held off until the write response returns.
  assign rd_hazard = (w_state != W_IDLE) ? same_line(d_rd_addr[31:4], awaddr[31:4])
                                         : (d_wr_req && same_line(d_rd_addr[31:4], d_wr_addr[31:4]));
  assign rd_en     = (r_state == R_IDLE) && !reset;
  assign rd_req    = {d_rd_req && !rd_hazard, i_rd_req};

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (rd_req),
    .en    (rd_en),
    .grant (rd_grant)
  );

  assign i_rd_rdy = rd_grant[0];
  assign d_rd_rdy = rd_grant[1];
  assign d_wr_rdy = (w_state == W_IDLE) && d_wr_req && !reset;

  assign arid    = r_owner_d ? ID_DCACHE : ID_ICACHE;
  assign arlen   = AXI_LEN_LINE;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign awid    = ID_DCACHE;
  assign awlen   = AXI_LEN_LINE;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = wr_line[31:0];
  assign wstrb   = 4'hf;
  assign wlast   = wvalid && (wbeat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= R_IDLE;
      arvalid     <= 1'b0;
      araddr      <= '0;
      r_owner_d   <= 1'b0;
      rready      <= 1'b0;
      rbeat       <= '0;
      ret_data    <= '0;
      i_ret_valid <= 1'b0;
      d_ret_valid <= 1'b0;
    end else begin
      i_ret_valid <= 1'b0;
      d_ret_valid <= 1'b0;
      unique case (r_state)
        R_IDLE: if (|rd_grant) begin
          araddr    <= (rd_grant[1] ? d_rd_addr : i_rd_addr) & LINE_MASK;
          r_owner_d <= rd_grant[1];
          arvalid   <= 1'b1;
          r_state   <= R_AR;
        end
        R_AR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          rbeat   <= '0;
          r_state <= R_DATA;
        end
        R_DATA: if (rvalid) begin
          ret_data[{rbeat, 5'd0} +: 32] <= rdata;
          rbeat <= rbeat + 2'd1;
          if (rlast) begin
            rready      <= 1'b0;
            i_ret_valid <= !r_owner_d;
            d_ret_valid <= r_owner_d;
            r_state     <= R_RET;
          end
        end
        R_RET:   r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // The latched line is shifted down one beat per W handshake so wdata is always bits [31:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      awaddr  <= '0;
      wvalid  <= 1'b0;
      wbeat   <= '0;
      wr_line <= '0;
      bready  <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: if (d_wr_rdy) begin
          awaddr  <= d_wr_addr & LINE_MASK;
          wr_line <= d_wr_data;
          awvalid <= 1'b1;
          w_state <= W_AW;
        end
        W_AW: if (awready) begin
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          wbeat   <= '0;
          w_state <= W_W;
        end
        W_W: if (wready) begin
          wr_line <= {32'h0, wr_line[127:32]};
          wbeat   <= wbeat + 2'd1;
          if (wlast) begin
            wvalid  <= 1'b0;
            bready  <= 1'b1;
            w_state <= W_B;
          end
        end
        W_B: if (bvalid) begin
          bready  <= 1'b0;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
